tc_frame_packer: RTL



---
 rtl/tc_frame_pkg.sv | 18 +
 rtl/tc_frame_stage.sv | 102 ++++++++++
 rtl/tc_frame_packer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tc_frame_pkg.sv
// Shared constants and types for the thermocouple frame packer.
// Frame layout: header, timestamp, then one data word per channel.
package tc_frame_pkg;

    localparam logic [7:0]  HDR_MAGIC   = 8'hA5;
    localparam int unsigned NUM_CH_DEF  = 8;
    localparam int unsigned FRAME_WORDS = NUM_CH_DEF + 2;
    localparam int unsigned ID_MSB      = 31;
    localparam int unsigned ID_LSB      = 24;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        TS,
        DATA
    } state_t;

endpackage

// File: rtl/tc_frame_stage.sv
// Staging slots, channel mask, duplicate detection and idle timeout.
// Closes a sweep and commits it into the output buffer when the stream is idle.
module tc_frame_stage
    import tc_frame_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned TS_W        = 32,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic              PL_clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_wr_en,
    input  logic [31:0]       i_data,
    input  logic [TS_W-1:0]   i_ts,
    input  logic              i_idle,
    input  logic [2:0]        i_rd_idx,
    output logic              o_close,
    output logic              o_commit,
    output logic              o_bad_id,
    output logic              o_dup,
    output logic [NUM_CH-1:0] o_close_mask,
    output logic [TS_W-1:0]   o_buf_ts,
    output logic [DATA_W-1:0] o_rd_code
);

    logic [7:0]        w_id;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_mask_nx;
    logic [NUM_CH-1:0] r_mask;
    logic [DATA_W-1:0] w_slot_nx  [NUM_CH];
    logic [DATA_W-1:0] r_slot     [NUM_CH];
    logic [DATA_W-1:0] r_buf_slot [NUM_CH];
    logic [TS_W-1:0]   w_ts_nx;
    logic [TS_W-1:0]   r_frame_ts;
    logic [TS_W-1:0]   r_buf_ts;
    logic [31:0]       r_timer;
    logic              w_accept;
    logic              w_timeout;

    // Next-state values include the sample accepted this cycle, so a closing
    // sample is part of the committed frame.
    always_comb begin
        w_id  = i_data[ID_MSB:ID_LSB];
        w_hit = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_hit[k] = (w_id == 8'(k + 1));
        end
        w_accept  = i_enable && i_wr_en && (w_hit != '0);
        o_bad_id  = i_enable && i_wr_en && (w_hit == '0);
        o_dup     = w_accept && ((w_hit & r_mask) != '0);
        w_mask_nx = w_accept ? (r_mask | w_hit) : r_mask;
        w_ts_nx   = (w_accept && (r_mask == '0)) ? i_ts : r_frame_ts;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_slot_nx[k] = (w_accept && w_hit[k]) ? i_data[DATA_W-1:0] : r_slot[k];
        end
        w_timeout    = i_enable && !i_wr_en && (r_mask != '0) &&
                       (r_timer == 32'(TIMEOUT_CYC - 1));
        o_close      = (w_accept && w_hit[NUM_CH-1]) || w_timeout;
        o_commit     = o_close && i_idle;
        o_close_mask = w_mask_nx;
        o_rd_code    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(i_rd_idx) == k) o_rd_code = r_buf_slot[k];
        end
    end

    assign o_buf_ts = r_buf_ts;

    always_ff @(posedge PL_clk or negedge rst) begin
        if (!rst) begin
            r_mask     <= '0;
            r_timer    <= '0;
            r_frame_ts <= '0;
            r_buf_ts   <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_slot[k]     <= '0;
                r_buf_slot[k] <= '0;
            end
        end else begin
            if (!i_enable || o_close) begin
                r_mask  <= '0;
                r_timer <= '0;
                for (int unsigned k = 0; k < NUM_CH; k++) r_slot[k] <= '0;
            end else begin
                r_mask     <= w_mask_nx;
                r_frame_ts <= w_ts_nx;
                for (int unsigned k = 0; k < NUM_CH; k++) r_slot[k] <= w_slot_nx[k];
                if (i_wr_en || (r_mask == '0)) r_timer <= '0;
                else                           r_timer <= r_timer + 32'd1;
            end
            if (o_commit) begin
                r_buf_ts <= w_ts_nx;
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    r_buf_slot[k] <= w_mask_nx[k] ? w_slot_nx[k] : '0;
                end
            end
        end
    end

endmodule

// File: rtl/tc_frame_packer.sv
// Packs one sweep of AD7124 thermocouple samples into a stamped frame
// and streams it out on an AXI4-Stream master.
module tc_frame_packer
    import tc_frame_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned TS_W        = 32,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic        PL_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clr_status,
    input  logic [31:0] TC_data,
    input  logic        wr_en,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] seq,
    output logic [15:0] drop_cnt,
    output logic [15:0] bad_id_cnt,
    output logic        dup_flag
);

    state_t            r_state;
    logic [2:0]        r_k;
    logic [TS_W-1:0]   r_ts;
    logic [15:0]       r_seq;
    logic [15:0]       r_drop;
    logic [15:0]       r_bad;
    logic              r_dup;
    logic [31:0]       r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              w_close;
    logic              w_commit;
    logic              w_bad_id;
    logic              w_dup;
    logic [NUM_CH-1:0] w_close_mask;
    logic [TS_W-1:0]   w_buf_ts;
    logic [DATA_W-1:0] w_code;
    logic [2:0]        w_rd_idx;

    // Look one word ahead: the code fetched now is registered onto tdata at the handshake.
    assign w_rd_idx = (r_state == DATA) ? (r_k + 3'd1) : 3'd0;

    tc_frame_stage #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .TS_W        (TS_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stage (
        .PL_clk       (PL_clk),
        .rst          (rst),
        .i_enable     (enable),
        .i_wr_en      (wr_en),
        .i_data       (TC_data),
        .i_ts         (r_ts),
        .i_idle       (r_state == IDLE),
        .i_rd_idx     (w_rd_idx),
        .o_close      (w_close),
        .o_commit     (w_commit),
        .o_bad_id     (w_bad_id),
        .o_dup        (w_dup),
        .o_close_mask (w_close_mask),
        .o_buf_ts     (w_buf_ts),
        .o_rd_code    (w_code)
    );

    always_ff @(posedge PL_clk or negedge rst) begin
        if (!rst) begin
            r_ts   <= '0;
            r_seq  <= '0;
            r_drop <= '0;
            r_bad  <= '0;
            r_dup  <= 1'b0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_close) r_seq <= r_seq + 16'd1;
            if (clr_status) begin
                r_drop <= '0;
                r_bad  <= '0;
                r_dup  <= 1'b0;
            end else begin
                if (w_close && !w_commit && (r_drop != '1)) r_drop <= r_drop + 16'd1;
                if (w_bad_id && (r_bad != '1))              r_bad  <= r_bad + 16'd1;
                if (w_dup)                                   r_dup  <= 1'b1;
            end
        end
    end

    always_ff @(posedge PL_clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_commit) begin
                    r_tdata  <= {HDR_MAGIC, 8'(w_close_mask), r_seq};
                    r_tvalid <= 1'b1;
                    r_tlast  <= 1'b0;
                    r_state  <= HDR;
                end
                HDR: if (m_axis_tready) begin
                    r_tdata <= 32'(w_buf_ts);
                    r_state <= TS;
                end
                TS: if (m_axis_tready) begin
                    r_tdata <= {8'd1, 24'(w_code)};
                    r_k     <= '0;
                    r_tlast <= (NUM_CH == 1);
                    r_state <= DATA;
                end
                DATA: if (m_axis_tready) begin
                    if (r_k == 3'(NUM_CH - 1)) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_tdata <= {8'(r_k) + 8'd2, 24'(w_code)};
                        r_tlast <= (r_k == 3'(NUM_CH - 2));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign seq           = r_seq;
    assign drop_cnt      = r_drop;
    assign bad_id_cnt    = r_bad;
    assign dup_flag      = r_dup;

endmodule
